// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//   state_t        : loader FSM states
//   BYTES_PER_WORD : bytes assembled into one memory word
//   LEN_WIDTH      : width of the word-count header field
package imem_loader_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned LEN_WIDTH      = 16;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        WRITE,
        CHK,
        DONE
    } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream and memory-write bundle of the instruction-memory loader.
//   in_valid/in_data/in_ready : byte stream, host -> loader
//   mem_we/mem_addr/mem_wdata : word write port, loader -> memory
// Modports: master = host/memory side, slave = loader side.
interface imem_loader_if #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 10
);

    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0]      mem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/imem_word_assembler.sv
// Byte-to-word shift register for the instruction-memory loader.
//   clk, reset  : clock, synchronous active-high reset
//   clear       : drop any partial word (start of a new load)
//   byte_valid  : byte_in is accepted this cycle
//   byte_in     : incoming byte, MSB-first within the word
//   load_en     : allow the completed word to update the word output
//   word        : last completed word, held until the next one completes
//   word_ready  : one-cycle flag, high the cycle after the last byte
//   last_byte   : the next accepted byte completes a word
module imem_word_assembler
    import imem_loader_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             byte_valid,
    input  logic [7:0]       byte_in,
    input  logic             load_en,
    output logic [WIDTH-1:0] word,
    output logic             word_ready,
    output logic             last_byte
);

    // Only the first three bytes need storing; the fourth joins them directly.
    logic [WIDTH-9:0] sr;
    logic [1:0]       cnt;

    assign last_byte = (cnt == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            sr         <= '0;
            cnt        <= '0;
            word       <= '0;
            word_ready <= 1'b0;
        end else if (clear) begin
            sr         <= '0;
            cnt        <= '0;
            word_ready <= 1'b0;
        end else begin
            word_ready <= 1'b0;
            if (byte_valid) begin
                sr  <= {sr[WIDTH-17:0], byte_in};
                cnt <= cnt + 2'd1;
                if (last_byte) begin
                    word_ready <= 1'b1;
                    // Words beyond memory depth must not disturb the held write data.
                    if (load_en) begin
                        word <= {sr, byte_in};
                    end
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: takes a big-endian byte stream
// (LEN_HI, LEN_LO, then LEN words MSB-first) and writes the words to
// memory from address 0 upward, holding the CPU while loading.
//   clk, reset : clock, synchronous active-high reset
//   start      : one-cycle pulse, begins a load from IDLE or DONE
//   bus        : byte stream in + memory write port (imem_loader_if.slave)
//   busy       : load in progress
//   done       : last load completed, held until next start/reset
//   overflow   : image exceeded memory depth, held until next start/reset
//   cpu_hold   : copy of busy
//   chk_err    : trailing checksum mismatch (only with IMEM_LOADER_CHECKSUM_EN)
// Build option: define IMEM_LOADER_CHECKSUM_EN to expect one trailing byte
// equal to the XOR of every preceding stream byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    imem_loader_if.slave bus,
    output logic         busy,
    output logic         done,
    output logic         overflow,
`ifdef IMEM_LOADER_CHECKSUM_EN
    output logic         chk_err,
`endif
    output logic         cpu_hold
);

    localparam int unsigned DEPTH = 32'd1 << ADDR_WIDTH;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t LAST_ST = CHK;
`else
    localparam state_t LAST_ST = DONE;
`endif

    state_t                state, state_nx;
    logic                  in_ready, mem_we, accept, start_go, ovf_word;
    logic                  asm_word_ready, asm_last_byte;
    logic [LEN_WIDTH-1:0]  len_q, word_cnt, cnt_inc;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [WIDTH-1:0]      asm_word;
    logic                  overflow_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]            xsum;
    logic                  chk_err_q;
`endif

    assign accept   = bus.in_valid && in_ready;
    assign start_go = start && (state == IDLE || state == DONE);
    assign cnt_inc  = word_cnt + LEN_WIDTH'(1);
    assign ovf_word = (32'(word_cnt) >= DEPTH);

    imem_word_assembler #(
        .WIDTH(WIDTH)
    ) u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (start_go),
        .byte_valid (accept && state == DATA),
        .byte_in    (bus.in_data),
        .load_en    (!ovf_word),
        .word       (asm_word),
        .word_ready (asm_word_ready),
        .last_byte  (asm_last_byte)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, DONE: if (start) state_nx = LEN_HI;
            LEN_HI:     if (accept) state_nx = LEN_LO;
            // An empty image has no words to checksum, so it finishes directly.
            LEN_LO:     if (accept) state_nx = ({len_q[LEN_WIDTH-1:8], bus.in_data} == '0) ? DONE : DATA;
            DATA:       if (accept && asm_last_byte) state_nx = WRITE;
            WRITE:      state_nx = (cnt_inc == len_q) ? LAST_ST : DATA;
            CHK:        if (accept) state_nx = DONE;
            default:    state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        mem_we   = 1'b0;
        unique case (state)
            LEN_HI, LEN_LO, DATA, CHK: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            WRITE: begin
                busy   = 1'b1;
                mem_we = asm_word_ready && !ovf_word;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len_q      <= '0;
            word_cnt   <= '0;
            addr_q     <= '0;
            overflow_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xsum       <= '0;
            chk_err_q  <= 1'b0;
`endif
        end else if (start_go) begin
            len_q      <= '0;
            word_cnt   <= '0;
            addr_q     <= '0;
            overflow_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xsum       <= '0;
            chk_err_q  <= 1'b0;
`endif
        end else begin
            if (accept && state == LEN_HI) len_q[LEN_WIDTH-1:8] <= bus.in_data;
            if (accept && state == LEN_LO) len_q[7:0]           <= bus.in_data;
            if (state == WRITE) begin
                word_cnt <= cnt_inc;
                if (ovf_word) overflow_q <= 1'b1;
                // Saturate rather than wrap so an oversized image never rewrites low memory.
                if (addr_q != '1) addr_q <= addr_q + ADDR_WIDTH'(1);
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (accept) begin
                if (state == CHK) chk_err_q <= (bus.in_data != xsum);
                else              xsum      <= xsum ^ bus.in_data;
            end
`endif
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = asm_word;
    assign overflow      = overflow_q;
    assign cpu_hold      = busy;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign chk_err       = chk_err_q;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader. Two instances: a full-size
// one (ADDR_WIDTH=10) and a 4-word one (ADDR_WIDTH=2) for overflow.
// Follows IMEM_LOADER_CHECKSUM_EN for the trailing checksum byte.
module tb_imem_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_a = 1'b0, start_s = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       sel_s = 1'b0;
    logic       busy_a, done_a, ovf_a, hold_a;
    logic       busy_s, done_s, ovf_s, hold_s;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic       chk_err_a, chk_err_s;
`endif

    int         n_checks = 0;
    int         n_errors = 0;
    int         viol = 0;
    logic [31:0] wa_addr[$], wa_data[$], ws_addr[$], ws_data[$];
    logic [7:0]  img[$];

    always #5 clk = ~clk;

    imem_loader_if #(.WIDTH(32), .ADDR_WIDTH(10)) bus_a ();
    imem_loader_if #(.WIDTH(32), .ADDR_WIDTH(2))  bus_s ();

    assign bus_a.in_valid = in_valid;
    assign bus_a.in_data  = in_data;
    assign bus_s.in_valid = in_valid;
    assign bus_s.in_data  = in_data;

    imem_loader #(.WIDTH(32), .ADDR_WIDTH(10)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start_a),
        .bus      (bus_a),
        .busy     (busy_a),
        .done     (done_a),
        .overflow (ovf_a),
`ifdef IMEM_LOADER_CHECKSUM_EN
        .chk_err  (chk_err_a),
`endif
        .cpu_hold (hold_a)
    );

    imem_loader #(.WIDTH(32), .ADDR_WIDTH(2)) u_small (
        .clk      (clk),
        .reset    (reset),
        .start    (start_s),
        .bus      (bus_s),
        .busy     (busy_s),
        .done     (done_s),
        .overflow (ovf_s),
`ifdef IMEM_LOADER_CHECKSUM_EN
        .chk_err  (chk_err_s),
`endif
        .cpu_hold (hold_s)
    );

    logic cur_ready, cur_done;
    assign cur_ready = sel_s ? bus_s.in_ready : bus_a.in_ready;
    assign cur_done  = sel_s ? done_s : done_a;

    // Record every memory write; a write while in_ready is high is an error.
    always @(negedge clk) begin
        if (bus_a.mem_we) begin
            wa_addr.push_back(32'(bus_a.mem_addr));
            wa_data.push_back(bus_a.mem_wdata);
            if (bus_a.in_ready) viol++;
        end
        if (bus_s.mem_we) begin
            ws_addr.push_back(32'(bus_s.mem_addr));
            ws_data.push_back(bus_s.mem_wdata);
            if (bus_s.in_ready) viol++;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        if (sel_s) start_s = 1'b1; else start_a = 1'b1;
        tick();
        start_s = 1'b0;
        start_a = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        while (!cur_ready && n < 40) begin
            n++;
            @(negedge clk);
        end
        check_val("handshake", 32'(cur_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_image(input bit gap);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < img.size(); i++) begin
            send_byte(img[i]);
            x ^= img[i];
            if (gap) tick();
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(x);
`else
        if (x == 8'h00) x = 8'h00;
`endif
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clk);
        while (!cur_done && n < 100) begin
            n++;
            @(negedge clk);
        end
        tick();
    endtask

    task automatic check_reset_a(input string tag);
        check_val({tag, "_in_ready"}, 32'(bus_a.in_ready), 32'd0);
        check_val({tag, "_mem_we"},   32'(bus_a.mem_we),   32'd0);
        check_val({tag, "_mem_addr"}, 32'(bus_a.mem_addr), 32'd0);
        check_val({tag, "_wdata"},    bus_a.mem_wdata,     32'd0);
        check_val({tag, "_busy"},     32'(busy_a),         32'd0);
        check_val({tag, "_done"},     32'(done_a),         32'd0);
        check_val({tag, "_overflow"}, 32'(ovf_a),          32'd0);
        check_val({tag, "_cpu_hold"}, 32'(hold_a),         32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick(); tick();
        reset = 1'b0;
        check_reset_a("rst");
        check_val("rst_small_done", 32'(done_s), 32'd0);

        // Two words, continuous stream
        pulse_start();
        check_val("t1_busy", 32'(busy_a), 32'd1);
        check_val("t1_hold", 32'(hold_a), 32'd1);
        img = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        send_image(1'b0);
        wait_done();
        check_val("t1_nwr",   32'(wa_addr.size()), 32'd2);
        check_val("t1_addr0", wa_addr[0], 32'd0);
        check_val("t1_data0", wa_data[0], 32'h12345678);
        check_val("t1_addr1", wa_addr[1], 32'd1);
        check_val("t1_data1", wa_data[1], 32'h9ABCDEF0);
        check_val("t1_done",  32'(done_a), 32'd1);
        check_val("t1_busy0", 32'(busy_a), 32'd0);
        check_val("t1_hold0", 32'(hold_a), 32'd0);
        check_val("t1_ovf",   32'(ovf_a),  32'd0);
        check_val("t1_addr_hold",  32'(bus_a.mem_addr), 32'd2);
        check_val("t1_wdata_hold", bus_a.mem_wdata, 32'h9ABCDEF0);

        // Empty image
        wa_addr.delete(); wa_data.delete();
        pulse_start();
        check_val("t2_done_clr", 32'(done_a), 32'd0);
        send_byte(8'h00);
        send_byte(8'h00);
        check_val("t2_done", 32'(done_a), 32'd1);
        tick();
        check_val("t2_nwr",  32'(wa_addr.size()), 32'd0);

        // One word with in_valid toggling
        pulse_start();
        img = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_image(1'b1);
        wait_done();
        check_val("t3_nwr",  32'(wa_addr.size()), 32'd1);
        check_val("t3_addr", wa_addr[0], 32'd0);
        check_val("t3_data", wa_data[0], 32'hDEADBEEF);
        check_val("t3_ready_during_write", 32'(viol), 32'd0);

        // Oversized image on the 4-word instance
        sel_s = 1'b1;
        pulse_start();
        img = '{8'h00, 8'h05};
        for (int w = 0; w < 5; w++) begin
            img.push_back(8'hA0); img.push_back(8'h00);
            img.push_back(8'h00); img.push_back(8'(w));
        end
        send_image(1'b0);
        wait_done();
        check_val("t4_nwr", 32'(ws_addr.size()), 32'd4);
        for (int w = 0; w < 4; w++) begin
            check_val($sformatf("t4_addr%0d", w), ws_addr[w], 32'(w));
            check_val($sformatf("t4_data%0d", w), ws_data[w], 32'hA0000000 + 32'(w));
        end
        check_val("t4_ovf",   32'(ovf_s), 32'd1);
        check_val("t4_done",  32'(done_s), 32'd1);
        check_val("t4_addr_sat", 32'(bus_s.mem_addr), 32'd3);
        check_val("t4_wdata_hold", bus_s.mem_wdata, 32'hA0000003);
        sel_s = 1'b0;

        // Reset in the middle of a word, then a clean reload
        wa_addr.delete(); wa_data.delete();
        pulse_start();
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h11); send_byte(8'h22);
        reset = 1'b1;
        tick();
        check_reset_a("t5");
        reset = 1'b0;
        tick();
        check_val("t5_nwr_abort", 32'(wa_addr.size()), 32'd0);
        pulse_start();
        img = '{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
        send_image(1'b0);
        wait_done();
        check_val("t5_nwr",  32'(wa_addr.size()), 32'd1);
        check_val("t5_addr", wa_addr[0], 32'd0);
        check_val("t5_data", wa_data[0], 32'hCAFEBABE);
        check_val("t5_done", 32'(done_a), 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // XOR of 00 01 01 02 03 04 is 0x05
        wa_addr.delete(); wa_data.delete();
        pulse_start();
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_byte(8'h05);
        wait_done();
        check_val("t6_good_err",  32'(chk_err_a), 32'd0);
        check_val("t6_good_done", 32'(done_a), 32'd1);
        check_val("t6_good_data", wa_data[0], 32'h01020304);
        pulse_start();
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_byte(8'hFF);
        wait_done();
        check_val("t6_bad_err",  32'(chk_err_a), 32'd1);
        check_val("t6_bad_done", 32'(done_a), 32'd1);
        pulse_start();
        check_val("t6_err_clr", 32'(chk_err_a), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
